// File: rtl/ppa_seq_pkg.sv
// Shared types and helpers for the nibble-serial prefix-adder sequencer.
package ppa_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index counting 0..n-1; never returns less than 1 bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ppa_nibble_slice.sv
// 4-bit Brent-Kung prefix adder slice with carry-in and carry-out, plus the
// pre/black/grey/post cells it is assembled from.
module ppa_pre_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);
  assign g = a & b;
  assign p = a ^ b;
endmodule

module ppa_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

module ppa_grey_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  output logic g
);
  assign g = g_hi | (p_hi & g_lo);
endmodule

module ppa_post_cell (
  input  logic p,
  input  logic c,
  output logic s
);
  assign s = p ^ c;
endmodule

module ppa_nibble_slice
  import ppa_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);
  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;
  logic             g32;
  logic             p32;

  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_pre
    ppa_pre_cell u_pre (.a(a[gi]), .b(b[gi]), .g(g[gi]), .p(p[gi]));
  end

  // cin acts as the generate term of a virtual bit -1, so c[i] is the
  // group generate of bits i-1..-1.
  assign c[0] = cin;
  ppa_grey_cell  u_c1  (.g_hi(g[0]), .p_hi(p[0]), .g_lo(c[0]), .g(c[1]));
  ppa_black_cell u_g32 (.g_hi(g[3]), .p_hi(p[3]), .g_lo(g[2]), .p_lo(p[2]),
                        .g(g32), .p(p32));
  ppa_grey_cell  u_c2  (.g_hi(g[1]), .p_hi(p[1]), .g_lo(c[1]), .g(c[2]));
  ppa_grey_cell  u_c4  (.g_hi(g32),  .p_hi(p32),  .g_lo(c[2]), .g(c[4]));
  ppa_grey_cell  u_c3  (.g_hi(g[2]), .p_hi(p[2]), .g_lo(c[2]), .g(c[3]));

  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_post
    ppa_post_cell u_post (.p(p[gi]), .c(c[gi]), .s(sum[gi]));
  end

  assign cout = c[NIB_W];
endmodule

// File: rtl/ppa_multiword_seq.sv
// WIDTH-bit adder that walks one shared 4-bit prefix slice over the operands,
// LSB nibble first. Define PPA_SEQ_SUB_EN to add the op_sub subtract port.
module ppa_multiword_seq
  import ppa_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PPA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB_CNT = WIDTH / NIB_W;
  localparam int IDX_W   = clog2(NIB_CNT);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("ppa_multiword_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             cout_reg;

  logic [WIDTH-1:0] b_cap;
  logic             cin_cap;
  logic             last_nib;

  logic [NIB_W-1:0] a_nib [NIB_CNT];
  logic [NIB_W-1:0] b_nib [NIB_CNT];
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;

  // Subtraction is a + ~b + 1, so the inversion happens once at capture.
`ifdef PPA_SEQ_SUB_EN
  assign b_cap   = op_sub ? ~b : b;
  assign cin_cap = op_sub | cin;
`else
  assign b_cap   = b;
  assign cin_cap = cin;
`endif

  assign last_nib = (idx_reg == IDX_W'(NIB_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_cap;
            carry_reg <= cin_cap;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          carry_reg <= slice_cout;
          if (last_nib) begin
            cout_reg <= slice_cout;
            idx_reg  <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NIB_CNT; gi++) begin : g_nib
    logic [NIB_W-1:0] nib_reg;

    assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
    assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        nib_reg <= '0;
      end else if (state_reg == RUN && idx_reg == IDX_W'(gi)) begin
        nib_reg <= slice_sum;
      end
    end

    assign sum[gi*NIB_W +: NIB_W] = nib_reg;
  end

  ppa_nibble_slice u_slice (
    .a    (a_nib[idx_reg]),
    .b    (b_nib[idx_reg]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign cout = cout_reg;

endmodule

// File: tb/tb_ppa_multiword_seq.sv
// Scoreboard bench: directed cases on a 16-bit instance, random traffic on
// 16-, 8- and 32-bit instances against an arithmetic reference.
`timescale 1ns/1ps
module tb_ppa_multiword_seq;
  localparam int W = 16;
`ifdef PPA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b1;
  logic         rand_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
`ifdef PPA_SEQ_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic [63:0]  exp_q[$];

  ppa_multiword_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PPA_SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Result packed as {cout, sum}: plain unsigned arithmetic on wide integers.
  function automatic logic [63:0] ref_model(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic c,
                                            input logic s);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (s) return ((x >= y) ? (64'd1 << w) : 64'd0) | ((x - y) & mask);
    return x + y + {63'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c, input logic s);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
`ifdef PPA_SEQ_SUB_EN
    op_sub = s;
`endif
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(W, 64'(x), 64'(y), c, s & SUB_EN));
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        return;
      end
      tick();
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    tick();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("dut16_unexpected", 64'({cout, sum}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        $display("dut16 result sum=%h cout=%b", sum, cout);
        chk("dut16_result", 64'({cout, sum}), e);
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rand
    localparam int RW = (gi == 0) ? 8 : 32;
    logic          r_rst = 1'b1;
    logic          r_in_valid = 1'b0;
    logic          r_cin = 1'b0;
    logic          r_out_ready = 1'b1;
    logic [RW-1:0] r_a = '0;
    logic [RW-1:0] r_b = '0;
    logic          r_in_ready, r_out_valid, r_cout, r_busy;
    logic [RW-1:0] r_sum;
`ifdef PPA_SEQ_SUB_EN
    logic          r_sub = 1'b0;
`endif
    logic [63:0]   rq[$];
    logic [RW-1:0] x, y;
    logic          c, s, acc;
    logic          done = 1'b0;

    ppa_multiword_seq #(.WIDTH(RW)) u_rdut (
      .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin),
`ifdef PPA_SEQ_SUB_EN
      .op_sub(r_sub),
`endif
      .out_valid(r_out_valid), .out_ready(r_out_ready), .sum(r_sum),
      .cout(r_cout), .busy(r_busy)
    );

    initial begin
      repeat (3) @(posedge clk);
      #1;
      r_rst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        x = RW'({$urandom, $urandom});
        y = RW'({$urandom, $urandom});
        c = 1'($urandom);
        s = 1'b0;
`ifdef PPA_SEQ_SUB_EN
        s = 1'($urandom_range(0, 1));
        r_sub = s;
`endif
        r_in_valid = 1'b1;
        r_a = x;
        r_b = y;
        r_cin = c;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
          @(negedge clk);
          if (r_in_ready) begin
            rq.push_back(ref_model(RW, 64'(x), 64'(y), c, s));
            acc = 1'b1;
          end
          @(posedge clk);
          #1;
          r_out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) chk("rand_accept_timeout", 64'(r_in_ready), 64'd1);
        r_in_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      r_out_ready = 1'b1;
      for (int t = 0; t < 500 && rq.size() != 0; t++) @(posedge clk);
      chk("rand_drain", 64'(rq.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!r_rst && r_out_valid && r_out_ready) begin
        if (rq.size() == 0) begin
          chk("rand_unexpected", 64'({r_cout, r_sum}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = rq.pop_front();
          $display("dut%0d result sum=%h cout=%b", RW, r_sum, r_cout);
          chk("rand_result", 64'({r_cout, r_sum}), e);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Carry ripples through every nibble; out_valid exactly 4 edges later.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      chk("t1_latency_valid", 64'(out_valid), 64'(j == 4));
    end
    drain();

    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      chk("t2_valid", 64'(out_valid), 64'(j == 4));
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      chk("t2_busy", 64'(busy), 64'd1);
    end
    drain();

    // Backpressure with a second operand set waiting.
    out_ready = 1'b0;
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("t3_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_sum", 64'(sum), 64'd0);
      chk("t3_hold_cout", 64'(cout), 64'd1);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_after_hs_in_ready", 64'(in_ready), 64'd1);
    chk("t3_after_hs_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(ref_model(W, 64'd1, 64'd2, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_accepted", 64'(busy), 64'd1);
    drain();

    // Reset sampled at the second RUN edge abandons the operation.
    send(16'h0F0F, 16'h0F0F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_sum", 64'(sum), 64'd0);
    chk("t4_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    drain();

`ifdef PPA_SEQ_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    drain();
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
    drain();
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    drain();
`endif

    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic s;
      s = 1'b0;
`ifdef PPA_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      send(W'($urandom), W'($urandom), 1'($urandom), s);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    for (int n = 0; n < 60000 && !(g_rand[0].done && g_rand[1].done); n++) @(posedge clk);
    chk("rand_blocks_done", 64'(g_rand[0].done & g_rand[1].done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
